// File: rtl/fft_dac_stream.sv
`timescale 1ns/1ps
// Sample-rate DAC streamer: a small FIFO feeds one CS-framed, MSB-first serial word
// per sample period. When the FIFO runs dry the previous sample is re-sent.
module fft_dac_stream #(
   parameter int DATA_W      = 16,
   parameter int FIFO_AW     = 4,
   parameter int SCLK_DIV    = 4,
   parameter int SMPL_PERIOD = 1134
) (
   input  logic              iCLK,
   input  logic              iRESET,
   input  logic              iEN,
   input  logic              iWR,
   input  logic [DATA_W-1:0] iDATA,
   output logic              oFULL,
   output logic              oEMPTY,
   output logic [FIFO_AW:0]  oLEVEL,
   output logic              oOVERFLOW,
   output logic              oUNDERRUN,
   output logic              oDAC_DATA,
   output logic              oDAC_CS,
   output logic              oDAC_CLK
);

   localparam int DEPTH = 2**FIFO_AW;
   localparam int PW    = $clog2(SMPL_PERIOD);
   localparam int DW    = $clog2(SCLK_DIV + 1);
   localparam int BW    = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH} state_t;

   logic [PW-1:0]     pace_cnt_reg;
   logic              tick;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [FIFO_AW:0]  wr_ptr_reg, rd_ptr_reg, wr_ptr_next, rd_ptr_next;
   logic [FIFO_AW:0]  level_reg;
   logic              full_reg, empty_reg, ovf_reg, und_reg;
   logic              push, start, pop;
   logic [DATA_W-1:0] head, frame_word;

   state_t            state_reg, state_next;
   logic [DW-1:0]     div_reg, div_next;
   logic [BW-1:0]     bit_reg, bit_next;
   logic [DATA_W-1:0] shift_reg, shift_next, last_reg, last_next;
   logic              cs_reg, cs_next, sclk_reg, sclk_next, sdata_reg, sdata_next;

   assign tick = iEN && (pace_cnt_reg == PW'(SMPL_PERIOD - 1));

   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET)
         pace_cnt_reg <= '0;
      else if (!iEN || tick)
         pace_cnt_reg <= '0;
      else
         pace_cnt_reg <= pace_cnt_reg + PW'(1);
   end

   // Full/empty are judged on the pre-edge state: a write while full is dropped even if
   // a pop happens on the same edge, and a write into an empty FIFO is not sent on that tick.
   assign push        = iWR && !full_reg;
   assign start       = tick && (state_reg == S_IDLE);
   assign pop         = start && !empty_reg;
   assign head        = mem[rd_ptr_reg[FIFO_AW-1:0]];
   assign frame_word  = empty_reg ? last_reg : head;
   assign wr_ptr_next = wr_ptr_reg + (FIFO_AW+1)'(push);
   assign rd_ptr_next = rd_ptr_reg + (FIFO_AW+1)'(pop);

   always_ff @(posedge iCLK) begin
      if (push)
         mem[wr_ptr_reg[FIFO_AW-1:0]] <= iDATA;
   end

   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
         full_reg   <= 1'b0;
         empty_reg  <= 1'b1;
         ovf_reg    <= 1'b0;
         und_reg    <= 1'b0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         level_reg  <= wr_ptr_next - rd_ptr_next;
         full_reg   <= (wr_ptr_next[FIFO_AW] != rd_ptr_next[FIFO_AW]) &&
                       (wr_ptr_next[FIFO_AW-1:0] == rd_ptr_next[FIFO_AW-1:0]);
         empty_reg  <= (wr_ptr_next == rd_ptr_next);
         ovf_reg    <= iWR && full_reg;
         und_reg    <= start && empty_reg;
      end
   end

   always_comb begin
      state_next = state_reg;
      div_next   = div_reg;
      bit_next   = bit_reg;
      shift_next = shift_reg;
      last_next  = last_reg;
      cs_next    = cs_reg;
      sclk_next  = sclk_reg;
      sdata_next = sdata_reg;
      case (state_reg)
         S_IDLE: begin
            cs_next    = 1'b1;
            sclk_next  = 1'b0;
            sdata_next = 1'b0;
            if (start) begin
               state_next = S_LOW;
               div_next   = '0;
               bit_next   = BW'(DATA_W);
               last_next  = frame_word;
               shift_next = frame_word;
               cs_next    = 1'b0;
               sdata_next = frame_word[DATA_W-1];
            end
         end
         S_LOW: begin
            if (div_reg == DW'(SCLK_DIV - 1)) begin
               div_next   = '0;
               sclk_next  = 1'b1;
               state_next = S_HIGH;
            end else begin
               div_next = div_reg + DW'(1);
            end
         end
         S_HIGH: begin
            if (div_reg == DW'(SCLK_DIV - 1)) begin
               div_next  = '0;
               sclk_next = 1'b0;
               if (bit_reg == BW'(1)) begin
                  state_next = S_IDLE;
                  cs_next    = 1'b1;
                  sdata_next = 1'b0;
               end else begin
                  // Next bit is presented on the falling edge of the serial clock.
                  bit_next   = bit_reg - BW'(1);
                  shift_next = shift_reg << 1;
                  sdata_next = shift_reg[DATA_W-2];
                  state_next = S_LOW;
               end
            end else begin
               div_next = div_reg + DW'(1);
            end
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge iCLK or negedge iRESET) begin
      if (!iRESET) begin
         state_reg <= S_IDLE;
         div_reg   <= '0;
         bit_reg   <= '0;
         shift_reg <= '0;
         last_reg  <= '0;
         cs_reg    <= 1'b1;
         sclk_reg  <= 1'b0;
         sdata_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         div_reg   <= div_next;
         bit_reg   <= bit_next;
         shift_reg <= shift_next;
         last_reg  <= last_next;
         cs_reg    <= cs_next;
         sclk_reg  <= sclk_next;
         sdata_reg <= sdata_next;
      end
   end

   assign oFULL     = full_reg;
   assign oEMPTY    = empty_reg;
   assign oLEVEL    = level_reg;
   assign oOVERFLOW = ovf_reg;
   assign oUNDERRUN = und_reg;
   assign oDAC_DATA = sdata_reg;
   assign oDAC_CS   = cs_reg;
   assign oDAC_CLK  = sclk_reg;

endmodule

// File: tb/tb_fft_dac_stream.sv
`timescale 1ns/1ps
// Scoreboard bench for fft_dac_stream: a queue-based model predicts each serial frame
// and the status flags; a monitor decodes the DAC pins and compares.
module tb_fft_dac_stream;
   localparam int DW    = 16;
   localparam int AW    = 2;
   localparam int SDIV  = 2;
   localparam int P     = 100;
   localparam int DEPTH = 4;

   logic          clk = 1'b0, rst_n = 1'b0, en = 1'b0, wr = 1'b0;
   logic [DW-1:0] din = '0;
   logic          full, empty, ovf, und, sdata, cs, sclk;
   logic [AW:0]   level;

   fft_dac_stream #(.DATA_W(DW), .FIFO_AW(AW), .SCLK_DIV(SDIV), .SMPL_PERIOD(P)) dut (
      .iCLK(clk), .iRESET(rst_n), .iEN(en), .iWR(wr), .iDATA(din),
      .oFULL(full), .oEMPTY(empty), .oLEVEL(level), .oOVERFLOW(ovf), .oUNDERRUN(und),
      .oDAC_DATA(sdata), .oDAC_CS(cs), .oDAC_CLK(sclk));

   always #5 clk = ~clk;

   int checks = 0, passes = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
   endtask

   // Reference model: the FIFO is a plain queue, one sample leaves per period.
   typedef struct { logic [DW-1:0] data; bit und; int start; } frame_t;
   frame_t        exp_q[$];
   logic [DW-1:0] mq[$];
   logic [DW-1:0] mlast = '0;
   int            mcnt = 0, cyc = 0;
   bit            m_ovf = 0, m_und = 0, m_tick, was_full, was_empty;

   initial forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
         mq.delete(); exp_q.delete();
         mlast = '0; mcnt = 0; m_ovf = 0; m_und = 0;
      end else begin
         cyc++;
         m_tick    = en && (mcnt == P - 1);
         mcnt      = (!en || m_tick) ? 0 : mcnt + 1;
         was_full  = (mq.size() == DEPTH);
         was_empty = (mq.size() == 0);
         m_ovf     = wr && was_full;
         m_und     = m_tick && was_empty;
         if (m_tick) begin
            if (!was_empty) mlast = mq.pop_front();
            exp_q.push_back('{mlast, was_empty, cyc});
         end
         if (wr && !was_full) mq.push_back(din);
      end
   end

   // Monitor: status every cycle, frame decode from the serial pins.
   int            n_frames = 0, ovf_cnt = 0, und_cnt = 0, nbits = 0, low_cnt = 0, start_cyc = 0;
   bit            in_frame = 0, prev_cs = 1, prev_clk = 0, prev_data = 0, und_seen = 0;
   logic [DW-1:0] word = '0, last_word = '0;
   frame_t        e;

   initial forever begin
      @(negedge clk);
      check("status lvl/full/empty/ovf/und", {level, full, empty, ovf, und},
            {3'(mq.size()), mq.size() == DEPTH, mq.size() == 0, m_ovf, m_und});
      if (ovf) ovf_cnt++;
      if (und) und_cnt++;
      if (!rst_n) begin
         in_frame = 0; prev_cs = 1; prev_clk = 0; prev_data = 0;
      end else begin
         if (prev_cs && !cs) begin
            in_frame = 1; nbits = 0; word = '0; low_cnt = 0; start_cyc = cyc; und_seen = und;
         end else if (in_frame && !cs && sdata != prev_data) begin
            check("data_changes_on_clk_fall", prev_clk && !sclk, 1);
         end
         if (in_frame && !cs) begin
            low_cnt++;
            if (!prev_clk && sclk) begin
               word = {word[DW-2:0], sdata};
               nbits++;
            end
         end
         if (in_frame && cs) begin
            in_frame = 0;
            check("frame_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("frame_data", word, e.data);
               check("frame_bits", nbits, DW);
               check("cs_low_cycles", low_cnt, 2 * SDIV * DW);
               check("frame_start_cycle", start_cyc, e.start);
               check("frame_underrun", und_seen, e.und);
            end
            last_word = word;
            n_frames++;
            $display("frame %0d: data %h underrun %0d start %0d", n_frames, word, und_seen, start_cyc);
         end
         prev_cs = cs; prev_clk = sclk; prev_data = sdata;
      end
   end

   task automatic write1(input logic [DW-1:0] v);
      @(negedge clk); wr = 1; din = v;
      @(negedge clk); wr = 0;
   endtask

   task automatic wait_frames(input int target, input int maxc);
      for (int i = 0; i < maxc && n_frames < target; i++) @(negedge clk);
      check("frame_wait", n_frames >= target, 1);
   endtask

   task automatic wait_cnt(input int v);
      bit ok = 0;
      for (int i = 0; i < 250 && !ok; i++) begin
         @(negedge clk);
         ok = en && (mcnt == v);
      end
      check("pacer_wait", ok, 1);
   endtask

   int o0, u0, f0;
   logic [DW-1:0] v;

   initial begin
      repeat (3) @(negedge clk);
      #1 check("reset_outputs", {cs, sclk, sdata, full, empty, level, ovf, und}, {3'b100, 2'b01, 3'd0, 2'b00});
      @(negedge clk); #2 rst_n = 1;

      // single frame
      f0 = n_frames;
      write1(16'hA55A);
      @(negedge clk); en = 1;
      wait_frames(f0 + 1, 250);
      check("single_word", last_word, 16'hA55A);
      en = 0;

      // fill and overflow, then drain into one underrun frame
      o0 = ovf_cnt; u0 = und_cnt; f0 = n_frames;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); wr = 1; din = 16'($urandom);
      end
      @(negedge clk); wr = 0;
      @(negedge clk);
      check("fill_full_level", {full, level}, {1'b1, 3'd4});
      check("fill_overflow_pulses", ovf_cnt - o0, 1);
      en = 1;
      wait_frames(f0 + 5, 700);
      check("drain_underrun_pulses", und_cnt - u0, 1);
      en = 0;

      // underrun repeats the held sample
      u0 = und_cnt; f0 = n_frames;
      write1(16'h1234);
      @(negedge clk); en = 1;
      wait_frames(f0 + 3, 450);
      check("underrun_pulses", und_cnt - u0, 2);
      check("underrun_word", last_word, 16'h1234);
      en = 0;

      // races: write while full on a pop tick, then write into empty on a tick
      o0 = ovf_cnt; u0 = und_cnt; f0 = n_frames;
      for (int i = 0; i < 4; i++) write1(16'($urandom));
      @(negedge clk); en = 1;
      wait_cnt(P - 1);
      wr = 1; din = 16'($urandom);
      @(negedge clk); wr = 0;
      check("race_full_pop_overflow", ovf_cnt - o0, 1);
      wait_frames(f0 + 4, 500);
      wait_cnt(P - 1);
      v = 16'($urandom);
      wr = 1; din = v;
      @(negedge clk); wr = 0;
      wait_frames(f0 + 6, 300);
      check("race_empty_underrun", und_cnt - u0, 1);
      check("race_late_sample_sent", last_word, v);
      en = 0;

      // wrap-around: keep the level between 1 and 3 for 10 samples
      o0 = ovf_cnt; u0 = und_cnt; f0 = n_frames;
      write1(16'($urandom)); write1(16'($urandom));
      @(negedge clk); en = 1;
      for (int i = 0; i < 8; i++) begin
         wait_cnt(50);
         wr = 1; din = 16'($urandom);
         @(negedge clk); wr = 0;
      end
      wait_frames(f0 + 10, 400);
      check("wrap_no_overflow", ovf_cnt - o0, 0);
      check("wrap_no_underrun", und_cnt - u0, 0);
      en = 0;

      // reset in the middle of a frame
      write1(16'($urandom)); write1(16'($urandom));
      @(negedge clk); en = 1;
      for (int i = 0; i < 250 && cs; i++) @(negedge clk);
      check("frame_began", cs, 0);
      repeat (2 + 7 * 2 * SDIV) @(negedge clk);
      #2 rst_n = 0;
      #1 check("midframe_reset_pins", {cs, sclk, sdata, empty, level}, {4'b1001, 3'd0});
      @(negedge clk); #2 rst_n = 1;
      f0 = n_frames;
      wait_frames(f0 + 1, 250);
      check("post_reset_word", {last_word, und_seen}, {16'h0000, 1'b1});
      en = 0;

      repeat (80) @(negedge clk);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/fft_dac_stream.md
# fft_dac_stream

Output-side sample streamer: accepts 16-bit samples from the processing/memory path into a small FIFO and transmits one sample per sample period to the serial DAC as a CS-framed, MSB-first SPI-style word. It is the transmit counterpart of the ADC capture path in the top level: it closes the ADC → memory → DAC loop at the 44.1 kHz sample rate. On underrun it re-sends the last sample so the analog output holds its level.

## Interface
- DATA_W, 16, sample width and bits per DAC frame
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW
- SCLK_DIV, 4, iCLK cycles per half period of oDAC_CLK (≥1)
- SMPL_PERIOD, 1134, iCLK cycles between frame starts (50 MHz / 44.1 kHz); must be > 2*SCLK_DIV*DATA_W + 1
- iCLK  in  1  system clock; all logic on rising edge
- iRESET  in  1  asynchronous, active-low reset
- iEN  in  1  enables the sample-rate pacer
- iWR  in  1  write strobe, one sample per high cycle
- iDATA  in  DATA_W  sample written when iWR=1
- oFULL  out  1  FIFO full
- oEMPTY  out  1  FIFO empty
- oLEVEL  out  FIFO_AW+1  number of stored samples
- oOVERFLOW  out  1  one-cycle pulse: write dropped
- oUNDERRUN  out  1  one-cycle pulse: frame started with FIFO empty
- oDAC_DATA  out  1  serial data, MSB first
- oDAC_CS  out  1  frame select, active low
- oDAC_CLK  out  1  serial clock, idle low

## Operation
- FIFO: circular buffer, write/read pointers FIFO_AW+1 bits wide (the extra bit distinguishes full from empty). Write accepted iff iWR=1 and oFULL=0 at that edge. If iWR=1 and oFULL=1: data dropped, oOVERFLOW=1 on the next cycle, even if a pop occurs in the same cycle (full is evaluated before the pop).
- Pacer: counter 0..SMPL_PERIOD-1, wraps. A tick is generated when the count equals SMPL_PERIOD-1. While iEN=0, the counter is held at 0, no ticks are generated, and any frame in progress completes.
- On a tick with the FSM in IDLE: if oEMPTY=0, pop the head into the shift register and the last-sample register. If oEMPTY=1, load the last-sample register and pulse oUNDERRUN. The empty check uses the pre-write state, so a same-cycle write is stored and not sent.
- FSM states:
  - IDLE: CS=1, CLK=0, DATA=0. On a tick, go to LOW.
  - LOW: CS=0, CLK=0 for SCLK_DIV cycles. On entry, DATA = current MSB. Then go to HIGH.
  - HIGH: CLK=1 for SCLK_DIV cycles. Then:
    - bits remain: shift left and go to LOW;
    - after bit 0: go to IDLE.
- The bit counter counts DATA_W down to 1. DATA changes only on CLK falling edges or at CS assertion; the DAC samples on the CLK rising edge.
- All serial outputs and status outputs are registered.

## Timing
- Reset values: oDAC_CS=1, oDAC_CLK=0, oDAC_DATA=0, oFULL=0, oEMPTY=1, oLEVEL=0, oOVERFLOW=0, oUNDERRUN=0. Pacer count, pointers and last sample are all 0.
- Reset asserted mid-frame: all outputs take their reset values immediately (asynchronously); the frame is aborted and the FIFO contents are discarded.
- Tick at cycle T: CS falls and the MSB appears at T+1. CLK first rises at T+1+SCLK_DIV. CS rises and CLK falls at T+1+2*SCLK_DIV*DATA_W.
- CS low time is exactly 2*SCLK_DIV*DATA_W cycles. Frame starts are exactly SMPL_PERIOD cycles apart while iEN=1.
- oLEVEL, oFULL and oEMPTY update one cycle after the write/pop edge.
- Simultaneous write and pop with 0 < level < depth: level unchanged.
- oUNDERRUN and oOVERFLOW are single-cycle pulses that accompany the offending event, registered one cycle later.
- Pointer wrap-around is transparent: the 2**FIFO_AW-th write returns the write address to 0.
- First tick occurs SMPL_PERIOD cycles after iEN rises.

## Test plan
Bench parameters: SCLK_DIV=2, SMPL_PERIOD=100, FIFO_AW=2, DATA_W=16.
- Single frame: write 16'hA55A, then raise iEN. Required:
  - CS low for 64 cycles;
  - 16 CLK rising edges sample the bits 1010_0101_0101_1010;
  - oLEVEL goes 1 → 0 on the pop.
- Fill and overflow: write 5 samples back-to-back with iEN=0. Required:
  - oFULL=1 and oLEVEL=4;
  - the 5th write is dropped and oOVERFLOW pulses once;
  - the streamed order is samples 1 to 4.
- Underrun: send 16'h1234, then leave the FIFO empty. Required:
  - the next frame re-sends 16'h1234;
  - oUNDERRUN pulses once per empty tick;
  - frames remain 100 cycles apart.
- Wrap-around: stream 10 samples while keeping the level at 1–3 by writing once per period. Required: all 10 values are received in order with no overflow or underrun.
- Reset mid-frame: assert iRESET at bit 7 of a frame. Required:
  - CS=1, CLK=0, DATA=0 immediately;
  - oEMPTY=1;
  - after release with iEN=1, the first frame starts 100 cycles later and is an underrun frame carrying 16'h0000.
- Edge races:
  - a write while full coinciding with a pop is dropped and oOVERFLOW pulses;
  - a write into an empty FIFO on the tick cycle gives oUNDERRUN, and that sample is sent on the following tick.
